// File: rtl/rng_chaos_sampler.sv
// rng_chaos_sampler
//   Wishbone-side sequencer for the rng_chaos core. While enabled it releases
//   the core from reset, discards a programmable number of warm-up cycles and
//   then takes one whitened 32-bit word from x/y/z every INTERVAL+1 cycles.
//   Words are queued in a small FIFO that firmware drains through DATA.
//
// Ports
//   wb_clk_i, wb_rst_i   sole clock, synchronous active-high reset
//   wbs_*                Wishbone classic slave (one wait state per access)
//   core_rst_no          rng_chaos reset, low while IDLE
//   core_x_i/y_i/z_i     rng_chaos state outputs
//   irq_o                data-available interrupt (IRQ_EN & FIFO not empty)
//
// Register map (word address = wbs_adr_i[3:2])
//   0 CTRL   [0] EN, [1] IRQ_EN, [2] FLUSH (write-only strobe, reads 0)
//   1 TIMING [CNT_W-1:0] WARMUP, [16+CNT_W-1:16] INTERVAL
//   2 STATUS [0] empty, [1] full, [2] overflow (W1C), [9:8] state, [20:16] level
//   3 DATA   read pops FIFO head (0 when empty); writes ignored

module rng_chaos_sampler #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        core_rst_no,
  input  logic [31:0] core_x_i,
  input  logic [31:0] core_y_i,
  input  logic [31:0] core_z_i,
  output logic        irq_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = AW + 1;
  localparam logic [15:0] HALF_MASK = 16'((32'd1 << CNT_W) - 32'd1);
  localparam logic [31:0] TIMING_MASK = {HALF_MASK, HALF_MASK};

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_TIMING = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_DATA   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Registers
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              ctrl_en_q, ctrl_en_d;
  logic              ctrl_irq_en_q, ctrl_irq_en_d;
  logic [31:0]       timing_q, timing_d;
  logic              overflow_q, overflow_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              irq_q, irq_d;
  logic [LW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [31:0]       mem_q [DEPTH];

  // Bus decode; side effects are taken on the ack cycle only.
  logic        bus_acc, bus_wr, bus_rd;
  logic [1:0]  reg_sel;
  logic [31:0] timing_wr;
  logic [31:0] rd_data;
  logic        unused_adr;

  assign bus_acc = ack_q & wbs_stb_i & wbs_cyc_i;
  assign bus_wr  = bus_acc & wbs_we_i;
  assign bus_rd  = bus_acc & ~wbs_we_i;
  assign reg_sel = wbs_adr_i[3:2];
  assign unused_adr = ^{wbs_adr_i[31:4], wbs_adr_i[1:0]};

  // Per-byte merge of a TIMING write.
  for (genvar gi = 0; gi < 4; gi++) begin : g_timing_byte
    assign timing_wr[gi*8 +: 8] =
      (bus_wr && reg_sel == REG_TIMING && wbs_sel_i[gi]) ? wbs_dat_i[gi*8 +: 8]
                                                         : timing_q[gi*8 +: 8];
  end

  // FIFO status
  logic [LW-1:0] level;
  logic          empty, full;
  logic [31:0]   head;
  logic [31:0]   sample;
  logic          push, pop, flush, push_ok, ovf_clr;

  assign level = wr_ptr_q - rd_ptr_q;
  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));
  assign head  = empty ? 32'd0 : mem_q[rd_ptr_q[AW-1:0]];

  // Whitening: x xor y rotated by 16 xor z rotated right by 8.
  assign sample = core_x_i ^ {core_y_i[15:0], core_y_i[31:16]}
                           ^ {core_z_i[7:0], core_z_i[31:8]};

  assign pop     = bus_rd & (reg_sel == REG_DATA) & ~empty;
  assign flush   = bus_wr & (reg_sel == REG_CTRL) & wbs_sel_i[0] & wbs_dat_i[2];
  assign ovf_clr = bus_wr & (reg_sel == REG_STATUS) & wbs_sel_i[0] & wbs_dat_i[2];
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push & ~flush & (~full | pop);

  // Sequencer: IDLE -> WARM (WARMUP+1 cycles) -> RUN (push every INTERVAL+1).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_en_q) begin
          state_d = ST_WARM;
          cnt_d   = timing_q[CNT_W-1:0];
        end
      end
      ST_WARM: begin
        if (!ctrl_en_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
          cnt_d   = timing_q[16 +: CNT_W];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          push  = 1'b1;
          cnt_d = timing_q[16 +: CNT_W];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
        if (!ctrl_en_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register file, FIFO pointers and outputs
  always_comb begin
    ack_d         = wbs_stb_i & wbs_cyc_i & ~ack_q;
    ctrl_en_d     = ctrl_en_q;
    ctrl_irq_en_d = ctrl_irq_en_q;
    if (bus_wr && reg_sel == REG_CTRL && wbs_sel_i[0]) begin
      ctrl_en_d     = wbs_dat_i[0];
      ctrl_irq_en_d = wbs_dat_i[1];
    end
    timing_d = timing_wr & TIMING_MASK;

    wr_ptr_d = wr_ptr_q + LW'(push_ok);
    rd_ptr_d = rd_ptr_q + LW'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end

    // Setting wins over a coincident W1C so a drop is never lost.
    overflow_d = overflow_q & ~ovf_clr;
    if (push && full && !pop && !flush) begin
      overflow_d = 1'b1;
    end

    core_rst_n_d = (state_d != ST_IDLE);
    irq_d        = ctrl_irq_en_q & ~empty;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      ack_q         <= 1'b0;
      ctrl_en_q     <= 1'b0;
      ctrl_irq_en_q <= 1'b0;
      timing_q      <= '0;
      overflow_q    <= 1'b0;
      core_rst_n_q  <= 1'b0;
      irq_q         <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ack_q         <= ack_d;
      ctrl_en_q     <= ctrl_en_d;
      ctrl_irq_en_q <= ctrl_irq_en_d;
      timing_q      <= timing_d;
      overflow_q    <= overflow_d;
      core_rst_n_q  <= core_rst_n_d;
      irq_q         <= irq_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // FIFO storage has no reset; pointers alone define validity.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= sample;
    end
  end

  // Read mux reflects the state of the ack cycle, matching the pop it causes.
  always_comb begin
    rd_data = 32'd0;
    case (reg_sel)
      REG_CTRL:   rd_data = {30'd0, ctrl_irq_en_q, ctrl_en_q};
      REG_TIMING: rd_data = timing_q;
      REG_STATUS: rd_data = {11'd0, 5'(level), 6'd0, state_q, 5'd0,
                             overflow_q, full, empty};
      REG_DATA:   rd_data = head;
      default:    rd_data = 32'd0;
    endcase
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = bus_rd ? rd_data : 32'd0;
  assign core_rst_no = core_rst_n_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_rng_chaos_sampler.sv
// Directed bench for rng_chaos_sampler. The core model drives x from a free
// running cycle counter (or a constant), so every FIFO word identifies the
// exact cycle in which it was pushed.

module tb_rng_chaos_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_w, adr;
  logic        ack;
  logic [31:0] dat_r;
  logic        core_rst_no;
  logic [31:0] core_x, core_y, core_z;
  logic        irq;

  logic [31:0] cyc_cnt = 32'd0;
  logic        x_const = 1'b0;
  logic [31:0] y_val = 32'd0;
  logic [31:0] z_val = 32'd0;
  logic [31:0] ack_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] A_CTRL   = 32'h0;
  localparam logic [31:0] A_TIMING = 32'h4;
  localparam logic [31:0] A_STATUS = 32'h8;
  localparam logic [31:0] A_DATA   = 32'hC;
  localparam logic [31:0] WHITE_YZ = 32'hFF00FFFF;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 32'd1;

  assign core_x = x_const ? 32'h12345678 : cyc_cnt;
  assign core_y = y_val;
  assign core_z = z_val;

  rng_chaos_sampler #(.DEPTH(4), .CNT_W(16)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (cyc),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_dat_i  (dat_w),
    .wbs_adr_i  (adr),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (dat_r),
    .core_rst_no(core_rst_no),
    .core_x_i   (core_x),
    .core_y_i   (core_y),
    .core_z_i   (core_z),
    .irq_o      (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-16s got=0x%08h", tag, got);
    end else begin
      $display("FAIL %-16s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One Wishbone access; ack_cnt records cyc_cnt during the ack cycle.
  task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd);
    bit done = 1'b0;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    rd = 32'd0;
    for (int i = 0; i < 4 && !done; i++) begin
      @(posedge clk);
      #1;
      if (ack) done = 1'b1;
    end
    rd = dat_r;
    ack_cnt = cyc_cnt;
    if (!done) check("wb_ack_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    wb_access(1'b1, a, d, s, dummy);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] rd);
    wb_access(1'b0, a, 32'd0, 4'hF, rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] c_a, c_b, c_d;
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
    dat_w = 32'd0; adr = 32'd0;

    // Reset
    step(2);
    rst = 1'b0;
    check("rst_core_rst_no", 32'(core_rst_no), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat_o", dat_r, 32'd0);
    wb_read(A_STATUS, rd); check("rst_status", rd, 32'h00000001);
    wb_read(A_CTRL, rd);   check("rst_ctrl", rd, 32'h0);
    wb_read(A_TIMING, rd); check("rst_timing", rd, 32'h0);
    wb_write(A_TIMING, 32'hFFFFFFFF, 4'b0101);
    wb_read(A_TIMING, rd); check("timing_bytesel", rd, 32'h00FF00FF);

    // Warm-up of 4 cycles, then one push per cycle until the FIFO overflows
    wb_write(A_TIMING, 32'h00000003, 4'hF);
    wb_write(A_CTRL, 32'h1, 4'hF);
    c_a = ack_cnt;
    check("en_core_rst_lag", 32'(core_rst_no), 32'd0);
    step(1);
    check("en_core_rst_no", 32'(core_rst_no), 32'd1);
    step(10);
    check("irq_disabled", 32'(irq), 32'd0);
    wb_write(A_CTRL, 32'h0, 4'hF);
    wb_read(A_STATUS, rd); check("ovf_status", rd, 32'h00040006);
    wb_write(A_STATUS, 32'h4, 4'h1);
    wb_read(A_STATUS, rd); check("ovf_w1c", rd, 32'h00040002);
    for (int k = 0; k < 4; k++) begin
      wb_read(A_DATA, rd);
      check($sformatf("warm_data%0d", k), rd, c_a + 32'd6 + 32'(k));
    end
    wb_read(A_DATA, rd);   check("data_empty", rd, 32'd0);
    wb_read(A_STATUS, rd); check("drained_status", rd, 32'h00000001);

    // Interval 2, whitening, and pop coinciding with a push while full
    y_val = 32'hFFFF0000;
    z_val = 32'h000000FF;
    wb_write(A_TIMING, 32'h00020000, 4'hF);
    wb_write(A_CTRL, 32'h1, 4'hF);
    c_b = ack_cnt;
    step(15);
    wb_read(A_DATA, rd);   check("full_pop_data", rd, (c_b + 32'd5) ^ WHITE_YZ);
    wb_read(A_STATUS, rd); check("full_pop_status", rd, 32'h00040202);
    wb_write(A_CTRL, 32'h0, 4'hF);
    wb_write(A_STATUS, 32'h4, 4'h1);
    wb_read(A_STATUS, rd); check("ivl_status", rd, 32'h00040002);
    for (int k = 1; k <= 4; k++) begin
      wb_read(A_DATA, rd);
      check($sformatf("ivl_data%0d", k), rd, (c_b + 32'd5 + 32'(3 * k)) ^ WHITE_YZ);
    end
    wb_read(A_STATUS, rd); check("ivl_drained", rd, 32'h00000001);

    // IRQ, disable and flush with constant core outputs
    x_const = 1'b1;
    wb_write(A_TIMING, 32'h00030000, 4'hF);
    wb_write(A_CTRL, 32'h3, 4'hF);
    c_d = ack_cnt;
    step(5);
    check("irq_before_push", 32'(irq), 32'd0);
    step(2);
    check("irq_after_push", 32'(irq), 32'd1);
    wb_read(A_DATA, rd);   check("white_const", rd, 32'hED34A987);
    wb_write(A_CTRL, 32'h2, 4'hF);
    step(1);
    check("dis_core_rst_no", 32'(core_rst_no), 32'd0);
    wb_read(A_STATUS, rd); check("dis_status", rd, 32'h00010000);
    check("irq_held", 32'(irq), 32'd1);
    wb_write(A_CTRL, 32'h6, 4'hF);
    wb_read(A_STATUS, rd); check("flush_status", rd, 32'h00000001);
    check("flush_irq", 32'(irq), 32'd0);
    wb_read(A_CTRL, rd);   check("ctrl_readback", rd, 32'h2);
    if (c_d == 32'd0) check("cycle_counter", c_d, 32'd1);

    // Reset in mid-operation
    wb_write(A_CTRL, 32'h1, 4'hF);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_rst_core", 32'(core_rst_no), 32'd0);
    wb_read(A_CTRL, rd);   check("mid_rst_ctrl", rd, 32'h0);
    wb_read(A_TIMING, rd); check("mid_rst_timing", rd, 32'h0);
    wb_read(A_STATUS, rd); check("mid_rst_status", rd, 32'h00000001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
